// File: rtl/la_pkg.sv
// Types and constants shared by the logic-analyzer protocol trigger units.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_trig_state_t;

  localparam int unsigned MIN_BAUD_DEFAULT = 4;

endpackage

// File: rtl/sync_fall_det.sv
// Synchronizer chain for an asynchronous line plus a falling-edge detector.
// All flops preload to 1 so an idle-high line never yields a spurious edge after reset.
module sync_fall_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      // Shift toward the MSB; the truncating cast drops the oldest stage.
      sync_q <= SYNC_STAGES'({sync_q, din});
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign fall = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_prot_trig.sv
// UART 8N1 deframer that pulses a trigger when a received byte equals a masked match value.
// Bits are sampled mid-cell by counting half a bit period from the start-bit falling edge.
module uart_prot_trig
  import la_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_BAUD    = MIN_BAUD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        en,
  input  logic [15:0] baud_cnt,
  input  logic [7:0]  match,
  input  logic [7:0]  mask,
  output logic        UARTtrig,
  output logic        frm_err,
  output logic [7:0]  rx_data
);

  logic rx_sync;
  logic fall;

  sync_fall_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_fall_det (
    .clk (clk),
    .rst (rst),
    .din (RX),
    .dout(rx_sync),
    .fall(fall)
  );

  uart_trig_state_t state_q;
  logic [15:0]      cnt_q;
  logic [15:0]      baud_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       rx_shift_q;

  logic [15:0] baud_eff;
  logic        expired;
  logic        hit;

  assign baud_eff = (baud_cnt < 16'(MIN_BAUD)) ? 16'(MIN_BAUD) : baud_cnt;
  assign expired  = (cnt_q == 16'd1);
  assign hit      = (((rx_shift_q ^ match) & ~mask) == 8'h00);

  always_ff @(posedge clk) begin
    UARTtrig <= 1'b0;
    frm_err  <= 1'b0;
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data    <= '0;
    end else if (!en) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            baud_q  <= baud_eff;
            cnt_q   <= baud_eff >> 1;
          end
        end
        START: begin
          if (expired) begin
            if (!rx_sync) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
              cnt_q     <= baud_q;
            end else begin
              // Start bit not low at mid-cell: treat as a glitch.
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (expired) begin
            rx_shift_q <= {rx_sync, rx_shift_q[7:1]};
            cnt_q      <= baud_q;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (expired) begin
            rx_data   <= rx_shift_q;
            UARTtrig  <= rx_sync & hit;
            frm_err   <= ~rx_sync;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
